remap_hist: RTL

Histogram stage directly downstream of `remap_top`. It consumes the 5-bit class code that `remap_top` produces on `rslt_o[31:27]` and keeps a saturating occurrence count per code value, 32 bins in total. Per-bin counts are read back through a one-cycle-latency read port. All counters clear through a 32-cycle sweep after reset or on request.

---
 rtl/remap_hist_if.sv | 27 ++
 rtl/remap_hist.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/remap_hist_if.sv
// Code-stream, clear and read-back signals of the remap_hist histogram stage.
// The master drives codes and requests; the slave is the histogram itself.
interface remap_hist_if #(
    parameter int CNT_W = 16
);
    logic             code_valid_i;
    logic [4:0]       code_i;
    logic             code_ready_o;
    logic             clear_i;
    logic             rd_req_i;
    logic [4:0]       rd_bin_i;
    logic             rd_valid_o;
    logic [CNT_W-1:0] rd_data_o;
    logic [CNT_W+4:0] total_o;
    logic             sat_o;
    logic             busy_o;

    modport master (
        output code_valid_i, code_i, clear_i, rd_req_i, rd_bin_i,
        input  code_ready_o, rd_valid_o, rd_data_o, total_o, sat_o, busy_o
    );

    modport slave (
        input  code_valid_i, code_i, clear_i, rd_req_i, rd_bin_i,
        output code_ready_o, rd_valid_o, rd_data_o, total_o, sat_o, busy_o
    );
endinterface

// File: rtl/remap_hist.sv
// 32-bin saturating histogram of remap_top class codes, with a one-cycle read
// port and a 32-cycle zeroing sweep after reset or clear.
module remap_hist #(
    parameter int CNT_W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    remap_hist_if.slave  bus
);
    localparam int TOT_W = CNT_W + 5;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e           state_r;
    state_e           state_nx_s;
    logic [4:0]       idx_r;
    logic             s1_v_r;
    logic [4:0]       s1_bin_r;
    logic [CNT_W-1:0] cnt_mem_r [32];
    logic [CNT_W-1:0] inc_val_s;
    logic [CNT_W-1:0] rd_val_s;
    logic [CNT_W-1:0] rd_data_r;
    logic [TOT_W-1:0] total_r;
    logic             sat_r;
    logic             rd_valid_r;
    logic             ready_r;
    logic             busy_r;
    logic             accept_s;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [TOT_W-1:0] sat_inc_tot(input logic [TOT_W-1:0] v);
        return (&v) ? v : v + TOT_W'(1);
    endfunction

    assign accept_s = bus.code_valid_i & ready_r & ~bus.clear_i;
    assign inc_val_s = sat_inc_cnt(cnt_mem_r[s1_bin_r]);

    // Next-state logic: the sweep ends after idx 31, clear always restarts it.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (bus.clear_i) begin
                    state_nx_s = ST_INIT;
                end else if (idx_r == 5'd31) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_INIT;
                end
            end
            ST_RUN: begin
                if (bus.clear_i) begin
                    state_nx_s = ST_INIT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_INIT;
        endcase
    end

    // Read value: the in-flight s1 increment is forwarded so the response
    // covers every code accepted before the request cycle.
    always_comb begin
        rd_val_s = '0;
        if (state_r == ST_INIT) begin
            rd_val_s = '0;
        end else if (s1_v_r && (s1_bin_r == bus.rd_bin_i)) begin
            rd_val_s = inc_val_s;
        end else begin
            rd_val_s = cnt_mem_r[bus.rd_bin_i];
        end
    end

    // Control, pipeline, totals and read-response registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r    <= ST_INIT;
            idx_r      <= 5'd0;
            s1_v_r     <= 1'b0;
            s1_bin_r   <= 5'd0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            rd_valid_r <= 1'b0;
            rd_data_r  <= '0;
            total_r    <= '0;
            sat_r      <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == ST_RUN);
            busy_r  <= (state_nx_s == ST_INIT);

            if (bus.clear_i) begin
                idx_r <= 5'd0;
            end else if (state_r == ST_INIT) begin
                idx_r <= idx_r + 5'd1;
            end else begin
                idx_r <= idx_r;
            end

            s1_v_r <= accept_s;
            if (accept_s) begin
                s1_bin_r <= bus.code_i;
            end else begin
                s1_bin_r <= s1_bin_r;
            end

            rd_valid_r <= bus.rd_req_i;
            if (bus.rd_req_i) begin
                rd_data_r <= rd_val_s;
            end else begin
                rd_data_r <= rd_data_r;
            end

            if (bus.clear_i) begin
                total_r <= '0;
                sat_r   <= 1'b0;
            end else if (s1_v_r) begin
                total_r <= sat_inc_tot(total_r);
                sat_r   <= sat_r | (&inc_val_s);
            end else begin
                total_r <= total_r;
                sat_r   <= sat_r;
            end
        end
    end

    // Single-port counter storage: the sweep zeroes one entry per cycle,
    // otherwise the s1 stage writes back its increment.
    always_ff @(posedge clk_i) begin
        if (rst_ni && (state_r == ST_INIT)) begin
            cnt_mem_r[idx_r] <= '0;
        end else if (rst_ni && s1_v_r && !bus.clear_i) begin
            cnt_mem_r[s1_bin_r] <= inc_val_s;
        end
    end

    assign bus.code_ready_o = ready_r;
    assign bus.busy_o       = busy_r;
    assign bus.rd_valid_o   = rd_valid_r;
    assign bus.rd_data_o    = rd_data_r;
    assign bus.total_o      = total_r;
    assign bus.sat_o        = sat_r;
endmodule
